// File: rtl/bip_pkg.sv
// rtl/bip_pkg.sv - shared types and constants for the BIP program loader
package bip_pkg;

  localparam int BYTE_W = 8;

  localparam logic [4:0] OPC_HLT  = 5'b00000;
  localparam logic [4:0] OPC_STO  = 5'b00001;
  localparam logic [4:0] OPC_LD   = 5'b00010;
  localparam logic [4:0] OPC_LDI  = 5'b00011;
  localparam logic [4:0] OPC_ADD  = 5'b00100;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_SUB  = 5'b00110;
  localparam logic [4:0] OPC_SUBI = 5'b00111;

  localparam logic [4:0] HALT_OPCODE_DEFAULT = OPC_HLT;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RX_HI = 3'd1,
    ST_RX_LO = 3'd2,
    ST_WRITE = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } loader_state_e;

endpackage

// File: rtl/bip_program_loader_if.sv
// rtl/bip_program_loader_if.sv - UART RX byte stream in, instruction-memory write port out
interface bip_program_loader_if #(
  parameter int NB_ADDR        = 11,
  parameter int NB_INSTRUCTION = 16
);
  import bip_pkg::*;

  logic [BYTE_W-1:0]         i_rx_data;
  logic                      i_rx_valid;
  logic [NB_ADDR-1:0]        o_mem_addr;
  logic [NB_INSTRUCTION-1:0] o_mem_data;
  logic                      o_mem_wr_enable;

  modport master (
    input  i_rx_data, i_rx_valid,
    output o_mem_addr, o_mem_data, o_mem_wr_enable
  );

  modport slave (
    output i_rx_data, i_rx_valid,
    input  o_mem_addr, o_mem_data, o_mem_wr_enable
  );

endinterface

// File: rtl/bip_loader_word_assembler.sv
// rtl/bip_loader_word_assembler.sv - pairs high/low bytes into a 16-bit word
// The high byte is held until the matching low byte arrives; word_valid is a same-cycle pulse.
module bip_loader_word_assembler
  import bip_pkg::*;
(
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [BYTE_W-1:0]     i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_accept_hi,
  input  logic                  i_accept_lo,
  output logic [2*BYTE_W-1:0]   o_word,
  output logic                  o_word_valid,
  output logic                  o_hi_strobe
);

  logic [BYTE_W-1:0] hi_q;
  logic              pending_q;

  assign o_hi_strobe  = i_rx_valid & i_accept_hi;
  assign o_word_valid = i_rx_valid & i_accept_lo & pending_q;
  assign o_word       = {hi_q, i_rx_data};

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      hi_q      <= '0;
      pending_q <= 1'b0;
    end else if (o_hi_strobe) begin
      hi_q      <= i_rx_data;
      pending_q <= 1'b1;
    end else if (o_word_valid) begin
      pending_q <= 1'b0;
    end
  end

endmodule

// File: rtl/bip_program_loader.sv
// rtl/bip_program_loader.sv - loads a UART byte stream into BIP instruction memory
// Optional LOADER_CHECKSUM_EN: trailing XOR checksum byte checked after the HLT word.
module bip_program_loader
  import bip_pkg::*;
#(
  parameter int               NB_INSTRUCTION = 16,
  parameter int               NB_ADDR        = 11,
  parameter int               NB_OPCODE      = 5,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  bip_program_loader_if.master bus,
  output logic                 o_cpu_reset,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic [NB_ADDR:0]     o_word_count
);

  loader_state_e             state_q, state_d;
  logic [NB_ADDR-1:0]        addr_q, addr_d;
  logic [NB_ADDR:0]          count_q, count_d;
  logic [NB_INSTRUCTION-1:0] data_q, data_d;
  logic                      wr_q, wr_d;
  logic                      cpu_rst_q, cpu_rst_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      error_q, error_d;

  logic                      is_hlt, is_full, last_word, armed_start;
  logic                      accept_hi, accept_lo, hi_strobe, word_valid;
  logic [2*BYTE_W-1:0]       word;

  assign is_hlt    = (data_q[NB_INSTRUCTION-1 -: NB_OPCODE] == HALT_OPCODE);
  assign is_full   = (addr_q == {NB_ADDR{1'b1}});
  assign last_word = is_hlt | is_full;
  // A byte seen during WRITE is the next high byte unless this word ends the load.
  assign accept_hi = (state_q == ST_RX_HI) | ((state_q == ST_WRITE) & ~last_word);
  assign accept_lo = (state_q == ST_RX_LO);
  assign armed_start = i_start &
                       ((state_q == ST_IDLE) | (state_q == ST_DONE) | (state_q == ST_ERROR));

  bip_loader_word_assembler u_asm (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_rx_data    (bus.i_rx_data),
    .i_rx_valid   (bus.i_rx_valid),
    .i_accept_hi  (accept_hi),
    .i_accept_lo  (accept_lo),
    .o_word       (word),
    .o_word_valid (word_valid),
    .o_hi_strobe  (hi_strobe)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (armed_start)
      csum_d = '0;
    else if (hi_strobe | word_valid)
      csum_d = csum_q ^ bus.i_rx_data;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) csum_q <= '0;
    else          csum_q <= csum_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (armed_start) begin
          state_d = ST_RX_HI;
          addr_d  = '0;
          count_d = '0;
        end
      end
      ST_RX_HI: if (hi_strobe) state_d = ST_RX_LO;
      ST_RX_LO: begin
        if (word_valid) begin
          state_d = ST_WRITE;
          data_d  = word;
          wr_d    = 1'b1;
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + 1'b1;
        count_d = count_q + 1'b1;
        if (is_hlt) begin
`ifdef LOADER_CHECKSUM_EN
          if (bus.i_rx_valid)
            state_d = (bus.i_rx_data == csum_q) ? ST_DONE : ST_ERROR;
          else
            state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end else if (is_full) begin
          state_d = ST_ERROR;
        end else begin
          state_d = hi_strobe ? ST_RX_LO : ST_RX_HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (bus.i_rx_valid)
          state_d = (bus.i_rx_data == csum_q) ? ST_DONE : ST_ERROR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    busy_d    = (state_d == ST_RX_HI) | (state_d == ST_RX_LO) |
                (state_d == ST_WRITE) | (state_d == ST_CHECK);
    done_d    = (state_d == ST_DONE);
    error_d   = (state_d == ST_ERROR);
    cpu_rst_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      cpu_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign bus.o_mem_addr      = addr_q;
  assign bus.o_mem_data      = data_q;
  assign bus.o_mem_wr_enable = wr_q;
  assign o_cpu_reset         = cpu_rst_q;
  assign o_busy              = busy_q;
  assign o_done              = done_q;
  assign o_error             = error_q;
  assign o_word_count        = count_q;

endmodule

// File: tb/tb_bip_program_loader.sv
// tb/tb_bip_program_loader.sv - directed self-checking bench for bip_program_loader
module tb_bip_program_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  bip_program_loader_if #(.NB_ADDR(11), .NB_INSTRUCTION(16)) bus ();
  bip_program_loader_if #(.NB_ADDR(2),  .NB_INSTRUCTION(16)) bus2 ();

  logic        cpu_rst, busy, done, err;
  logic [11:0] wc;
  logic        cpu_rst2, busy2, done2, err2;
  logic [2:0]  wc2;

  bip_program_loader #(.NB_ADDR(11)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_start(start), .bus(bus),
    .o_cpu_reset(cpu_rst), .o_busy(busy), .o_done(done), .o_error(err),
    .o_word_count(wc)
  );

  bip_program_loader #(.NB_ADDR(2)) dut2 (
    .i_clock(clk), .i_reset(rst_n), .i_start(start2), .bus(bus2),
    .o_cpu_reset(cpu_rst2), .o_busy(busy2), .o_done(done2), .o_error(err2),
    .o_word_count(wc2)
  );

  logic [10:0] wa [$];
  logic [15:0] wd [$];
  logic [1:0]  wa2 [$];
  logic [15:0] wd2 [$];

  always @(negedge clk) begin
    if (bus.o_mem_wr_enable === 1'b1) begin
      wa.push_back(bus.o_mem_addr);
      wd.push_back(bus.o_mem_data);
    end
    if (bus2.o_mem_wr_enable === 1'b1) begin
      wa2.push_back(bus2.o_mem_addr);
      wd2.push_back(bus2.o_mem_data);
    end
  end

  task automatic clear_log();
    wa.delete(); wd.delete(); wa2.delete(); wd2.delete();
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start2 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start2 = 1'b0;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b);
    if (sel) begin bus2.i_rx_data = b; bus2.i_rx_valid = 1'b1; end
    else     begin bus.i_rx_data  = b; bus.i_rx_valid  = 1'b1; end
    @(posedge clk); #1;
    bus.i_rx_valid = 1'b0; bus2.i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input bit sel, input logic [7:0] hi, input logic [7:0] lo);
    send_byte(sel, hi);
    send_byte(sel, lo);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({bus.o_mem_addr, bus.o_mem_data, bus.o_mem_wr_enable} !== 28'h0) begin
      fails++; $display("FAIL reset_mem got %h want 0", {bus.o_mem_addr, bus.o_mem_data, bus.o_mem_wr_enable});
    end
    tests++;
    if ({done, cpu_rst, err, busy, wc} !== 16'h0) begin
      fails++; $display("FAIL reset_status got %h want 0", {done, cpu_rst, err, busy, wc});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    logic [10:0] ea [3] = '{11'd0, 11'd1, 11'd2};
    logic [15:0] ed [3] = '{16'h0805, 16'h1803, 16'h0000};
    clear_log();
    pulse_start(1'b0);
    tests++;
    if ({done, cpu_rst, err, busy} !== 4'b0001) begin
      fails++; $display("FAIL load_armed got %b want 0001", {done, cpu_rst, err, busy});
    end
    send_word(1'b0, 8'h08, 8'h05);
    send_word(1'b0, 8'h18, 8'h03);
    send_word(1'b0, 8'h00, 8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_byte(1'b0, 8'h16);
`endif
    @(posedge clk); #1;
    tests++;
    if (wa.size() != 3) begin
      fails++; $display("FAIL load_nwrites got %0d want 3", wa.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (i < wa.size()) begin
        tests++;
        if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
          fails++; $display("FAIL load_write%0d got %h@%0d want %h@%0d", i, wd[i], wa[i], ed[i], ea[i]);
        end
      end
    end
    tests++;
    if ({done, cpu_rst, err, busy} !== 4'b1100 || wc !== 12'd3) begin
      fails++; $display("FAIL load_done got %b cnt %0d want 1100 cnt 3", {done, cpu_rst, err, busy}, wc);
    end
  endtask

  task automatic test_restart();
    clear_log();
    pulse_start(1'b0);
    tests++;
    if ({done, cpu_rst, err, busy} !== 4'b0001 || wc !== 12'd0) begin
      fails++; $display("FAIL restart_armed got %b cnt %0d want 0001 cnt 0", {done, cpu_rst, err, busy}, wc);
    end
    send_word(1'b0, 8'h2A, 8'h55);
    tests++;
    if (wa.size() < 1 || wa[0] !== 11'd0 || wd[0] !== 16'h2A55) begin
      fails++; $display("FAIL restart_first_write got %0d writes want 2a55@0", wa.size());
    end
    send_word(1'b0, 8'h00, 8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_byte(1'b0, 8'h7F);
`endif
    @(posedge clk); #1;
    tests++;
    if ({done, cpu_rst, err, busy} !== 4'b1100 || wc !== 12'd2) begin
      fails++; $display("FAIL restart_done got %b cnt %0d want 1100 cnt 2", {done, cpu_rst, err, busy}, wc);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] ea [3] = '{11'd0, 11'd1, 11'd2};
    logic [15:0] ed [3] = '{16'h0805, 16'h1803, 16'h0000};
    clear_log();
    pulse_start(1'b0);
    send_byte(1'b0, 8'h08);
    send_byte(1'b0, 8'h05);
    tests++;
    if (bus.o_mem_wr_enable !== 1'b1 || bus.o_mem_addr !== 11'd0 || bus.o_mem_data !== 16'h0805) begin
      fails++; $display("FAIL b2b_latency got we=%b %h@%0d want 1 0805@0",
                        bus.o_mem_wr_enable, bus.o_mem_data, bus.o_mem_addr);
    end
    send_byte(1'b0, 8'h18);
    send_byte(1'b0, 8'h03);
    send_byte(1'b0, 8'h00);
    send_byte(1'b0, 8'h00);
    @(posedge clk); #1;
`ifdef LOADER_CHECKSUM_EN
    send_byte(1'b0, 8'h16);
`endif
    @(posedge clk); #1;
    tests++;
    if (wa.size() != 3) begin
      fails++; $display("FAIL b2b_nwrites got %0d want 3", wa.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (i < wa.size()) begin
        tests++;
        if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
          fails++; $display("FAIL b2b_write%0d got %h@%0d want %h@%0d", i, wd[i], wa[i], ed[i], ea[i]);
        end
      end
    end
    tests++;
    if ({done, cpu_rst, err, busy} !== 4'b1100 || wc !== 12'd3) begin
      fails++; $display("FAIL b2b_done got %b cnt %0d want 1100 cnt 3", {done, cpu_rst, err, busy}, wc);
    end
  endtask

  task automatic test_overflow();
    clear_log();
    pulse_start(1'b1);
    for (int i = 1; i <= 4; i++) send_word(1'b1, 8'h08, 8'(i));
    @(posedge clk); #1;
    tests++;
    if (wa2.size() != 4) begin
      fails++; $display("FAIL ovf_nwrites got %0d want 4", wa2.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < wa2.size()) begin
        tests++;
        if (wa2[i] !== 2'(i) || wd2[i] !== (16'h0801 + 16'(i))) begin
          fails++; $display("FAIL ovf_write%0d got %h@%0d want %h@%0d", i, wd2[i], wa2[i], 16'h0801 + 16'(i), i);
        end
      end
    end
    tests++;
    if ({done2, cpu_rst2, err2, busy2} !== 4'b0010 || wc2 !== 3'd4) begin
      fails++; $display("FAIL ovf_error got %b cnt %0d want 0010 cnt 4", {done2, cpu_rst2, err2, busy2}, wc2);
    end
  endtask

  task automatic test_reset_midload();
    clear_log();
    pulse_start(1'b0);
    send_byte(1'b0, 8'h08);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({done, cpu_rst, err, busy, wc} !== 16'h0 ||
        {bus.o_mem_addr, bus.o_mem_data, bus.o_mem_wr_enable} !== 28'h0) begin
      fails++; $display("FAIL midreset_outputs got %h/%h want 0/0", {done, cpu_rst, err, busy, wc},
                        {bus.o_mem_addr, bus.o_mem_data, bus.o_mem_wr_enable});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (wa.size() != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL midreset_nowrite got %0d writes busy %b want 0 writes busy 0", wa.size(), busy);
    end
  endtask

  task automatic test_start_collision();
    clear_log();
    bus.i_rx_data = 8'hAA; bus.i_rx_valid = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    bus.i_rx_valid = 1'b0; start = 1'b0;
    send_word(1'b0, 8'h08, 8'h05);
    send_word(1'b0, 8'h00, 8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_byte(1'b0, 8'h0D);
`endif
    @(posedge clk); #1;
    tests++;
    if (wa.size() != 2 || wd[0] !== 16'h0805 || wa[0] !== 11'd0) begin
      fails++; $display("FAIL collision_writes got %0d writes want 2 starting 0805@0", wa.size());
    end
    tests++;
    if ({done, cpu_rst, err, busy} !== 4'b1100 || wc !== 12'd2) begin
      fails++; $display("FAIL collision_done got %b cnt %0d want 1100 cnt 2", {done, cpu_rst, err, busy}, wc);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start(1'b0);
    send_word(1'b0, 8'h08, 8'h05);
    send_word(1'b0, 8'h00, 8'h00);
    tests++;
    if ({done, cpu_rst, err, busy} !== 4'b0001) begin
      fails++; $display("FAIL csum_wait got %b want 0001", {done, cpu_rst, err, busy});
    end
    send_byte(1'b0, 8'h0D);
    tests++;
    if ({done, cpu_rst, err, busy} !== 4'b1100) begin
      fails++; $display("FAIL csum_good got %b want 1100", {done, cpu_rst, err, busy});
    end
    pulse_start(1'b0);
    send_word(1'b0, 8'h08, 8'h05);
    send_word(1'b0, 8'h00, 8'h00);
    send_byte(1'b0, 8'h0E);
    tests++;
    if ({done, cpu_rst, err, busy} !== 4'b0010) begin
      fails++; $display("FAIL csum_bad got %b want 0010", {done, cpu_rst, err, busy});
    end
  endtask
`endif

  initial begin
    bus.i_rx_data = 8'h00;  bus.i_rx_valid = 1'b0;
    bus2.i_rx_data = 8'h00; bus2.i_rx_valid = 1'b0;
    test_reset();
    test_load();
    test_restart();
    test_back_to_back();
    test_overflow();
    test_reset_midload();
    test_start_collision();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
